turfio_command_decoder: RTL

- Sits directly downstream of the TURFIO CIN parallelizer, in the aclk domain.
- Consumes the 32-bit command words and their valid strobe.
- Decodes each word into four things: trigger requests, run-control commands with a run-state machine, sync pulses, and 4-byte framed control messages.
- Keeps saturating error and drop counters for readout by the control/status register block.

---
 rtl/turfio_command_decoder.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/turfio_command_decoder.sv
// turfio_command_decoder
//   Decodes 32-bit TURFIO CIN command words (aclk domain) into trigger
//   requests, run-control pulses with a STOPPED/RUNNING state machine,
//   sync pulses and 4-byte framed control messages. It also keeps
//   saturating error and drop counters.
//
// Ports
//   aclk_i                command clock
//   rst_i                 asynchronous active-high reset
//   cin_locked_i          parallelizer lock; words are accepted only while high
//   command_i             command word
//   command_valid_i       command word strobe
//   cnt_rst_i             synchronous clear of all counters
//   trig_o / trig_time_o  trigger pulse / trigger time (held)
//   sync_o                sync pulse
//   run_rst_o, run_start_o, run_stop_o  run-control pulses
//   running_o             1 = RUNNING
//   msg_o / msg_valid_o   assembled message (held) / completion pulse
//   framing_err_count_o, reserved_err_count_o, dropped_trig_count_o  counters
module turfio_command_decoder #(
  parameter int unsigned COUNT_WIDTH       = 16,
  parameter logic        TRIG_WHEN_STOPPED = 1'b0
) (
  input  logic                   aclk_i,
  input  logic                   rst_i,
  input  logic                   cin_locked_i,
  input  logic [31:0]            command_i,
  input  logic                   command_valid_i,
  input  logic                   cnt_rst_i,
  output logic                   trig_o,
  output logic [14:0]            trig_time_o,
  output logic                   sync_o,
  output logic                   run_rst_o,
  output logic                   run_start_o,
  output logic                   run_stop_o,
  output logic                   running_o,
  output logic [31:0]            msg_o,
  output logic                   msg_valid_o,
  output logic [COUNT_WIDTH-1:0] framing_err_count_o,
  output logic [COUNT_WIDTH-1:0] reserved_err_count_o,
  output logic [COUNT_WIDTH-1:0] dropped_trig_count_o
);

  localparam int unsigned TIME_W = 15;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned PART_W = 24;

  typedef enum logic {
    STOPPED = 1'b0,
    RUNNING = 1'b1
  } run_state_t;

  typedef enum logic [1:0] {
    M_IDLE = 2'd0,
    M_B1   = 2'd1,
    M_B2   = 2'd2,
    M_B3   = 2'd3
  } msg_state_t;

  run_state_t              run_state, run_next;
  msg_state_t              msg_state, msg_next;
  logic [PART_W-1:0]       part_q, part_next;

  logic                    trig_d, sync_d, run_rst_d, run_start_d, run_stop_d, msg_valid_d;
  logic [TIME_W-1:0]       trig_time_d;
  logic [31:0]             msg_d;
  logic                    fe_inc, re_inc, dt_inc;
  logic [COUNT_WIDTH-1:0]  fe_d, re_d, dt_d;

  logic                    accept;
  logic [BYTE_W-1:0]       cmd_byte;

  assign accept    = command_valid_i & cin_locked_i;
  assign cmd_byte  = command_i[23:16];
  assign running_o = (run_state == RUNNING);

  // Saturating increment with clear taking priority.
  function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] v,
                                                     input logic inc, input logic clr);
    if (clr)
      return '0;
    else if (inc && (v != '1))
      return v + COUNT_WIDTH'(1);
    else
      return v;
  endfunction

  // Next-state and registered-output decode.
  always_comb begin
    run_next    = run_state;
    msg_next    = msg_state;
    part_next   = part_q;
    trig_d      = 1'b0;
    trig_time_d = trig_time_o;
    sync_d      = 1'b0;
    run_rst_d   = 1'b0;
    run_start_d = 1'b0;
    run_stop_d  = 1'b0;
    msg_d       = msg_o;
    msg_valid_d = 1'b0;
    fe_inc      = 1'b0;
    re_inc      = 1'b0;
    dt_inc      = 1'b0;

    if (accept) begin
      re_inc = |command_i[31:29];
      sync_d = command_i[28];

      // Trigger gating uses the run state before this word's run command.
      if (command_i[15]) begin
        if ((run_state == RUNNING) || TRIG_WHEN_STOPPED) begin
          trig_d      = 1'b1;
          trig_time_d = command_i[14:0];
        end else begin
          dt_inc = 1'b1;
        end
      end

      unique case (command_i[27:26])
        2'b01: begin
          run_rst_d = 1'b1;
          run_next  = STOPPED;
        end
        2'b10: begin
          if (run_state == STOPPED) begin
            run_start_d = 1'b1;
            run_next    = RUNNING;
          end
        end
        2'b11: begin
          if (run_state == RUNNING) begin
            run_stop_d = 1'b1;
            run_next   = STOPPED;
          end
        end
        default: ;
      endcase

      if (command_i[24]) begin
        if (command_i[25]) begin
          // SOM always restarts the message; it is an error unless idle.
          fe_inc             = (msg_state != M_IDLE);
          part_next[23:16]   = cmd_byte;
          msg_next           = M_B1;
        end else begin
          unique case (msg_state)
            M_IDLE: fe_inc = 1'b1;
            M_B1: begin
              part_next[15:8] = cmd_byte;
              msg_next        = M_B2;
            end
            M_B2: begin
              part_next[7:0] = cmd_byte;
              msg_next       = M_B3;
            end
            M_B3: begin
              msg_d       = {part_q, cmd_byte};
              msg_valid_d = 1'b1;
              msg_next    = M_IDLE;
            end
            default: msg_next = M_IDLE;
          endcase
        end
      end
    end else if (!cin_locked_i) begin
      // Losing lock silently abandons any partial message.
      msg_next = M_IDLE;
    end

    fe_d = sat_inc(framing_err_count_o, fe_inc, cnt_rst_i);
    re_d = sat_inc(reserved_err_count_o, re_inc, cnt_rst_i);
    dt_d = sat_inc(dropped_trig_count_o, dt_inc, cnt_rst_i);
  end

  // State and output registers.
  always_ff @(posedge aclk_i or posedge rst_i) begin
    if (rst_i) begin
      run_state            <= STOPPED;
      msg_state            <= M_IDLE;
      part_q               <= '0;
      trig_o               <= 1'b0;
      trig_time_o          <= '0;
      sync_o               <= 1'b0;
      run_rst_o            <= 1'b0;
      run_start_o          <= 1'b0;
      run_stop_o           <= 1'b0;
      msg_o                <= '0;
      msg_valid_o          <= 1'b0;
      framing_err_count_o  <= '0;
      reserved_err_count_o <= '0;
      dropped_trig_count_o <= '0;
    end else begin
      run_state            <= run_next;
      msg_state            <= msg_next;
      part_q               <= part_next;
      trig_o               <= trig_d;
      trig_time_o          <= trig_time_d;
      sync_o               <= sync_d;
      run_rst_o            <= run_rst_d;
      run_start_o          <= run_start_d;
      run_stop_o           <= run_stop_d;
      msg_o                <= msg_d;
      msg_valid_o          <= msg_valid_d;
      framing_err_count_o  <= fe_d;
      reserved_err_count_o <= re_d;
      dropped_trig_count_o <= dt_d;
    end
  end

endmodule
